// File: rtl/hwm_pkg.sv
// hwm_pkg: shared constants, id-width helper and result record for the half-word match arbiter
package hwm_pkg;

  localparam logic [15:0] MATCH_VAL_DEF = 16'h0001;

  // Width of a requester index: clog2(n), never less than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Result record; id is sized for the largest supported requester count (8).
  typedef struct packed {
    logic [2:0] id;
    logic       flag;
  } hwm_res_t;

endpackage

// File: rtl/halfword_match.sv
// halfword_match: flag is 0 only when both halves of word equal MATCH_VAL
module halfword_match
  import hwm_pkg::*;
#(
  parameter int                      DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH/2-1:0] MATCH_VAL  = MATCH_VAL_DEF
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  flag
);

  localparam int HW = DATA_WIDTH / 2;

  assign flag = !((word[DATA_WIDTH-1:HW] == MATCH_VAL) & (word[HW-1:0] == MATCH_VAL));

endmodule

// File: rtl/halfword_match_arbiter.sv
// halfword_match_arbiter: round-robin share of one registered half-word match unit; HWM_STATS_EN adds per-requester match counters
module halfword_match_arbiter
  import hwm_pkg::*;
#(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      REQ_CNT    = 2,
  parameter logic [DATA_WIDTH/2-1:0] MATCH_VAL  = MATCH_VAL_DEF,
  parameter int                      CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_CNT-1:0]            req_valid,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
  output logic [REQ_CNT-1:0]            req_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [id_w(REQ_CNT)-1:0]      res_id,
`ifdef HWM_STATS_EN
  input  logic                          stat_clr,
  output logic [REQ_CNT*CNT_WIDTH-1:0]  stat_match,
`endif
  output logic                          res_flag
);

  localparam int IDW = id_w(REQ_CNT);

  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        gnt;
  logic [IDW-1:0]        idx;
  logic                  gnt_vld;
  logic                  acc;
  logic                  can_accept;
  logic                  flag;
  logic [DATA_WIDTH-1:0] word;

  assign can_accept = !res_valid | res_ready;
  assign acc        = gnt_vld & can_accept;
  assign req_ready  = acc ? (REQ_CNT'(1) << gnt) : '0;

  // Round-robin scan from rr_ptr; walking offsets downward leaves the nearest valid requester as winner.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % REQ_CNT);
      if (req_valid[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  // Steer the granted requester's word into the single shared match unit.
  always_comb begin
    word = '0;
    for (int k = 0; k < REQ_CNT; k++)
      if (gnt == IDW'(k)) word = req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  halfword_match #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATCH_VAL  (MATCH_VAL)
  ) u_match (
    .word (word),
    .flag (flag)
  );

  // Result register: load on accept (also when popping in the same cycle), drop on a pop without accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_flag  <= 1'b0;
      rr_ptr    <= '0;
    end else if (acc) begin
      res_valid <= 1'b1;
      res_id    <= gnt;
      res_flag  <= flag;
      rr_ptr    <= (gnt == IDW'(REQ_CNT - 1)) ? '0 : gnt + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef HWM_STATS_EN
  logic [CNT_WIDTH-1:0] cnt [REQ_CNT];

  for (genvar i = 0; i < REQ_CNT; i++) begin : g_stat
    assign stat_match[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  // Count consumed matching results per requester, saturating; clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REQ_CNT; k++) cnt[k] <= '0;
    end else if (stat_clr) begin
      for (int k = 0; k < REQ_CNT; k++) cnt[k] <= '0;
    end else if (res_valid & res_ready & !res_flag & ~&cnt[res_id]) begin
      cnt[res_id] <= cnt[res_id] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_halfword_match_arbiter.sv
// tb_halfword_match_arbiter: directed and randomized checks against a behavioural model of the arbiter
module tb_halfword_match_arbiter;
  import hwm_pkg::*;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam logic [31:0] MW = 32'h0001_0001;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_data;
  logic [N-1:0]       req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [id_w(N)-1:0] res_id;
  logic               res_flag;
  logic               stat_clr;
  logic [N*CW-1:0]    stat_match;

  int checks   = 0;
  int failures = 0;

  hwm_res_t m_res;
  logic     m_v;
  int       m_ptr;
  int       m_cnt [N];

  always #5 clk = ~clk;

  halfword_match_arbiter #(
    .DATA_WIDTH (W),
    .REQ_CNT    (N),
    .MATCH_VAL  (16'h0001),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
`ifdef HWM_STATS_EN
    .stat_clr   (stat_clr),
    .stat_match (stat_match),
`endif
    .res_flag   (res_flag)
  );

`ifndef HWM_STATS_EN
  assign stat_match = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v   = 1'b0;
    m_res = '0;
    m_ptr = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  function automatic logic is_match(input logic [31:0] w);
    return ((w >> 16) == 1) && ((w % 65536) == 1);
  endfunction

  // One clock: drive at negedge, compare shortly after, advance the model at posedge.
  task automatic cyc(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                     input logic rdy, input logic clr);
    int g;
    bit acc;
    bit vb [N];
    logic [31:0] w;
    @(negedge clk);
    req_valid = v;
    req_data  = {b, a};
    res_ready = rdy;
    stat_clr  = clr;
    vb[0] = v[0];
    vb[1] = v[1];
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && vb[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    acc = (g >= 0) && (!m_v || rdy);
    #1;
    chk("req_ready", 32'(req_ready), acc ? (32'd1 << g) : 32'd0);
    chk("res_valid", 32'(res_valid), 32'(m_v));
    chk("res_id", 32'(res_id), 32'(m_res.id));
    chk("res_flag", 32'(res_flag), 32'(m_res.flag));
`ifdef HWM_STATS_EN
    chk("stat_match0", 32'(stat_match[CW-1:0]), m_cnt[0]);
    chk("stat_match1", 32'(stat_match[2*CW-1:CW]), m_cnt[1]);
`endif
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else if (m_v && rdy && !m_res.flag && m_cnt[m_res.id] < 255) begin
      m_cnt[m_res.id]++;
    end
    if (acc) begin
      w          = (g == 1) ? b : a;
      m_v        = 1'b1;
      m_res.id   = 3'(g);
      m_res.flag = !is_match(w);
      m_ptr      = (g + 1) % N;
    end else if (rdy) begin
      m_v = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [15:0] hi, lo;
    hi = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'($urandom);
    lo = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'($urandom);
    return {hi, lo};
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    stat_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_flag", 32'(res_flag), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_stat", 32'(stat_match), 0);

    cyc(2'b01, MW, 32'h0, 1'b1, 1'b0);
    #1;
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_id", 32'(res_id), 0);
    chk("t1_flag", 32'(res_flag), 0);

    cyc(2'b10, 32'h0, 32'h0001_0002, 1'b1, 1'b0);
    #1;
    chk("t2_id", 32'(res_id), 1);
    chk("t2_flag", 32'(res_flag), 1);
    cyc(2'b01, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    #1;
    chk("t2_zero_flag", 32'(res_flag), 1);

    cyc(2'b01, MW, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(2'b11, 32'hDEAD_0000 + 32'(k), MW, 1'b0, 1'b0);
      #1;
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_valid", 32'(res_valid), 1);
    end
    cyc(2'b11, 32'h0001_0003, MW, 1'b1, 1'b0);

    @(negedge clk);
    req_valid = '0;
    res_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(res_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(res_valid), 0);
    chk("async_rst_id", 32'(res_id), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      cyc(2'b11, 32'(k), MW, 1'b1, 1'b0);
      #1;
      chk("alt_id", 32'(res_id), k % 2);
      chk("alt_valid", 32'(res_valid), 1);
    end

    for (int k = 0; k < 400; k++)
      cyc(2'($urandom), rnd_word(), rnd_word(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));

`ifdef HWM_STATS_EN
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 300; k++) cyc(2'b01, MW, 32'h0, 1'b1, 1'b0);
    #1;
    chk("stat_sat", 32'(stat_match[CW-1:0]), 255);
    cyc(2'b01, MW, 32'h0, 1'b1, 1'b1);
    #1;
    chk("stat_clr_prio", 32'(stat_match[CW-1:0]), 0);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("stat_after_clr", 32'(stat_match[CW-1:0]), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
